demod_block_ctrl: RTL

//  Block-level sequencer for the FM demod datapath (demod_top).

---
 rtl/demod_block_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/demod_block_ctrl.sv
// Block-level sequencer for the FM demod datapath: issues source samples into the demod,
// retires demod outputs downstream, bounds in-flight samples. Optional: DEMOD_CTRL_STATS_EN.
module demod_block_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    block_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  input  logic                    src_empty,
  output logic                    src_rd_en,
  input  logic [2*DATA_WIDTH-1:0] src_dout,
  input  logic                    dm_full,
  output logic                    dm_wr_en,
  output logic [DATA_WIDTH-1:0]   dm_real,
  output logic [DATA_WIDTH-1:0]   dm_imag,
  input  logic                    dm_empty,
  output logic                    dm_rd_en,
  input  logic [DATA_WIDTH-1:0]   dm_dout,
  input  logic                    dst_full,
  output logic                    dst_wr_en,
  output logic [DATA_WIDTH-1:0]   dst_din,
  output logic [CNT_WIDTH-1:0]    issued_cnt,
  output logic [CNT_WIDTH-1:0]    retired_cnt
`ifdef DEMOD_CTRL_STATS_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;

  logic [CNT_WIDTH-1:0] w_inflight;
  logic [CNT_WIDTH-1:0] w_issued_nxt;
  logic [CNT_WIDTH-1:0] w_retired_nxt;
  logic                 w_run;
  logic                 w_drain;
  logic                 w_flush;
  logic                 w_issue;
  logic                 w_pop;

  assign w_run   = (r_state == S_RUN);
  assign w_drain = (r_state == S_DRAIN);
  assign w_flush = (r_state == S_FLUSH);

  assign w_inflight = r_issued - r_retired;

  // The in-flight cap is what keeps the demod output FIFO from overflowing.
  assign w_issue = w_run && !abort && !src_empty && !dm_full &&
                   (r_issued < r_len) &&
                   (w_inflight < CNT_WIDTH'(MAX_INFLIGHT));

  // Flushing discards words, so the downstream full flag does not gate it.
  assign w_pop = (w_run || w_drain || w_flush) && !dm_empty &&
                 (r_retired < r_issued) && (w_flush || !dst_full);

  assign w_issued_nxt  = r_issued  + CNT_WIDTH'(w_issue);
  assign w_retired_nxt = r_retired + CNT_WIDTH'(w_pop);

  assign src_rd_en   = w_issue;
  assign dm_wr_en    = w_issue;
  assign dm_real     = src_dout[2*DATA_WIDTH-1:DATA_WIDTH];
  assign dm_imag     = src_dout[DATA_WIDTH-1:0];
  assign dm_rd_en    = w_pop;
  assign dst_wr_en   = w_pop && !w_flush;
  assign dst_din     = dm_dout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign issued_cnt  = r_issued;
  assign retired_cnt = r_retired;

  // NOTE: state is updated with non-blocking assignments so every register in this
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_issued  <= '0;
      r_retired <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_issued  <= w_issued_nxt;
      r_retired <= w_retired_nxt;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= block_len;
            r_issued  <= '0;
            r_retired <= '0;
            r_aborted <= 1'b0;
            if (block_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_FLUSH;
          end else if (w_issued_nxt == r_len) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // A final retire wins over a coincident abort.
          if (w_retired_nxt == r_len) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (abort) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_retired_nxt == w_issued_nxt) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMOD_CTRL_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if (r_busy && !w_issue && !w_pop && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
